// File: rtl/op_imm_pipe.sv
// Two-stage OP-IMM / OP-IMM-32 execute unit with valid/ready backpressure and flush.
// S1 registers the decoded operands; S2 registers the computed result and illegal flag.
module op_imm_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [11:0]      in_imm,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int         SH        = (XLEN == 64) ? 6 : 5;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [11-SH:0] SRA_UP = {1'b0, 1'b1, {(10-SH){1'b0}}};

    logic             s1_valid_q, s1_valid_d;
    logic [6:0]       s1_opcode_q, s1_opcode_d;
    logic [2:0]       s1_funct3_q, s1_funct3_d;
    logic [11:0]      s1_imm_q, s1_imm_d;
    logic [XLEN-1:0]  s1_simm_q, s1_simm_d;
    logic [XLEN-1:0]  s1_rs1_q, s1_rs1_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_illegal_q, out_illegal_d;

    logic             s2_ready, accept, s1_adv;
    logic [XLEN-1:0]  exe_res;
    logic             exe_ill;
    logic [11-SH:0]   up_bits;
    logic [SH-1:0]    shamt;
    logic [31:0]      w_res;

    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = (!s1_valid_q || s2_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign s1_adv   = s1_valid_q && s2_ready;

    assign up_bits = s1_imm_q[11:SH];
    assign shamt   = s1_imm_q[SH-1:0];

    always_comb begin
        exe_res = '0;
        exe_ill = 1'b0;
        w_res   = '0;
        case (s1_opcode_q)
            OP_IMM: begin
                case (s1_funct3_q)
                    3'b000: exe_res = s1_rs1_q + s1_simm_q;
                    3'b010: exe_res = XLEN'($signed(s1_rs1_q) < $signed(s1_simm_q));
                    3'b011: exe_res = XLEN'(s1_rs1_q < s1_simm_q);
                    3'b100: exe_res = s1_rs1_q ^ s1_simm_q;
                    3'b110: exe_res = s1_rs1_q | s1_simm_q;
                    3'b111: exe_res = s1_rs1_q & s1_simm_q;
                    3'b001: begin
                        if (up_bits == '0) exe_res = s1_rs1_q << shamt;
                        else               exe_ill = 1'b1;
                    end
                    default: begin
                        if (up_bits == '0)         exe_res = s1_rs1_q >> shamt;
                        else if (up_bits == SRA_UP) exe_res = $signed(s1_rs1_q) >>> shamt;
                        else                        exe_ill = 1'b1;
                    end
                endcase
            end
            OP_IMM_32: begin
                // Word ops exist only on the 64-bit datapath.
                if (XLEN != 64) begin
                    exe_ill = 1'b1;
                end else begin
                    case (s1_funct3_q)
                        3'b000: w_res = s1_rs1_q[31:0] + s1_simm_q[31:0];
                        3'b001: begin
                            if (s1_imm_q[11:5] == 7'b0000000) w_res = s1_rs1_q[31:0] << s1_imm_q[4:0];
                            else                              exe_ill = 1'b1;
                        end
                        3'b101: begin
                            if (s1_imm_q[11:5] == 7'b0000000)
                                w_res = s1_rs1_q[31:0] >> s1_imm_q[4:0];
                            else if (s1_imm_q[11:5] == 7'b0100000)
                                w_res = $signed(s1_rs1_q[31:0]) >>> s1_imm_q[4:0];
                            else
                                exe_ill = 1'b1;
                        end
                        default: exe_ill = 1'b1;
                    endcase
                    exe_res = XLEN'($signed(w_res));
                end
            end
            default: exe_ill = 1'b1;
        endcase
        if (exe_ill) exe_res = '0;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_opcode_d = s1_opcode_q;
        s1_funct3_d = s1_funct3_q;
        s1_imm_d    = s1_imm_q;
        s1_simm_d   = s1_simm_q;
        s1_rs1_d    = s1_rs1_q;
        s1_tag_d    = s1_tag_q;
        if (accept) begin
            s1_opcode_d = in_opcode;
            s1_funct3_d = in_funct3;
            s1_imm_d    = in_imm;
            s1_simm_d   = XLEN'($signed(in_imm));
            s1_rs1_d    = in_rs1;
            s1_tag_d    = in_tag;
        end
        if (flush)       s1_valid_d = 1'b0;
        else if (accept) s1_valid_d = 1'b1;
        else if (s1_adv) s1_valid_d = 1'b0;
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_tag_d     = out_tag_q;
        out_illegal_d = out_illegal_q;
        if (s1_adv) begin
            out_result_d  = exe_res;
            out_tag_d     = s1_tag_q;
            out_illegal_d = exe_ill;
        end
        if (flush)          out_valid_d = 1'b0;
        else if (s1_adv)    out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_opcode_q   <= '0;
            s1_funct3_q   <= '0;
            s1_imm_q      <= '0;
            s1_simm_q     <= '0;
            s1_rs1_q      <= '0;
            s1_tag_q      <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_tag_q     <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_opcode_q   <= s1_opcode_d;
            s1_funct3_q   <= s1_funct3_d;
            s1_imm_q      <= s1_imm_d;
            s1_simm_q     <= s1_simm_d;
            s1_rs1_q      <= s1_rs1_d;
            s1_tag_q      <= s1_tag_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_tag_q     <= out_tag_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_op_imm_pipe.sv
// Bench for op_imm_pipe: a 32-bit and a 64-bit instance share one stimulus stream
// and are checked against a queue-based reference model of the pipeline.
module tb_op_imm_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [11:0] in_imm;
    logic [63:0] in_rs1;
    logic [4:0]  in_tag;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_result32;
    logic [4:0]  out_tag32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_result64;
    logic [4:0]  out_tag64;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    op_imm_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_imm(in_imm), .in_rs1(in_rs1[31:0]),
        .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .out_result(out_result32), .out_tag(out_tag32), .out_illegal(out_illegal32));

    op_imm_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_imm(in_imm), .in_rs1(in_rs1),
        .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .out_result(out_result64), .out_tag(out_tag64), .out_illegal(out_illegal64));

    // Reference: {illegal, result} straight from the ISA rules.
    function automatic logic [64:0] ref_op(input int xl, input logic [6:0] op, input logic [2:0] f3,
                                           input logic [11:0] imm, input logic [63:0] rs1);
        logic [63:0] mask, a, s, r;
        longint      sa, ss;
        int          sh;
        logic [11:0] up;
        logic [31:0] w;
        logic        ill;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a    = rs1 & mask;
        s    = {{52{imm[11]}}, imm} & mask;
        sa   = (xl == 64) ? longint'(a) : longint'({{32{a[31]}}, a[31:0]});
        ss   = (xl == 64) ? longint'(s) : longint'({{32{s[31]}}, s[31:0]});
        sh   = (xl == 64) ? int'(imm[5:0]) : int'(imm[4:0]);
        up   = (xl == 64) ? (imm >> 6) : (imm >> 5);
        ill  = 1'b0;
        r    = '0;
        w    = '0;
        if (op == 7'h13) begin
            case (f3)
                3'd0: r = (a + s) & mask;
                3'd2: r = (sa < ss) ? 64'd1 : 64'd0;
                3'd3: r = (a < s) ? 64'd1 : 64'd0;
                3'd4: r = a ^ s;
                3'd6: r = a | s;
                3'd7: r = a & s;
                3'd1: if (up == 12'h0) r = (a << sh) & mask; else ill = 1'b1;
                default: begin
                    if (up == 12'h0) r = a >> sh;
                    else if (up == ((xl == 64) ? 12'h010 : 12'h020)) r = 64'(sa >>> sh) & mask;
                    else ill = 1'b1;
                end
            endcase
        end else if (op == 7'h1B && xl == 64) begin
            case (f3)
                3'd0: w = a[31:0] + s[31:0];
                3'd1: if (imm[11:5] == 7'h00) w = a[31:0] << imm[4:0]; else ill = 1'b1;
                3'd5: begin
                    if (imm[11:5] == 7'h00)      w = a[31:0] >> imm[4:0];
                    else if (imm[11:5] == 7'h20) w = 32'($signed(a[31:0]) >>> imm[4:0]);
                    else ill = 1'b1;
                end
                default: ill = 1'b1;
            endcase
            r = {{32{w[31]}}, w};
        end else begin
            ill = 1'b1;
        end
        if (ill) r = '0;
        return {ill, r};
    endfunction

    typedef struct {
        logic [4:0]  tag;
        logic [64:0] e32;
        logic [64:0] e64;
        int          age;
    } ent_t;

    ent_t q[$];
    ent_t p_e;
    logic p_pop, p_push, p_clear;
    logic [4:0] got_tags[$];

    // Pipeline occupancy model: an op is visible once it has seen two edges.
    function automatic logic m_out_valid();
        return (q.size() > 0) && (q[0].age >= 2);
    endfunction

    function automatic logic m_in_ready();
        return !flush && ((q.size() < 2) || out_ready);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            p_pop = 1'b0; p_push = 1'b0; p_clear = 1'b0;
            if (rst) begin
                p_clear = 1'b1;
            end else begin
                p_clear = flush;
                p_pop   = m_out_valid() && out_ready;
                p_push  = in_valid && m_in_ready();
                p_e.tag = in_tag;
                p_e.e32 = ref_op(32, in_opcode, in_funct3, in_imm, in_rs1);
                p_e.e64 = ref_op(64, in_opcode, in_funct3, in_imm, in_rs1);
                p_e.age = 1;
            end
            @(posedge clk);
            if (p_clear) begin
                q.delete();
            end else begin
                if (p_pop) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
                if (p_push) q.push_back(p_e);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid32 && out_ready) got_tags.push_back(out_tag32);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] imm,
                         input logic [63:0] rs1, input logic [4:0] tag);
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_imm = imm; in_rs1 = rs1; in_tag = tag;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_cmp += 8;
        if (out_valid32 !== 1'b0)   begin n_fail++; $display("FAIL rst_valid32 got %b exp 0", out_valid32); end
        if (out_result32 !== 32'h0) begin n_fail++; $display("FAIL rst_result32 got %h exp 0", out_result32); end
        if (out_tag32 !== 5'h0)     begin n_fail++; $display("FAIL rst_tag32 got %h exp 0", out_tag32); end
        if (out_illegal32 !== 1'b0) begin n_fail++; $display("FAIL rst_illegal32 got %b exp 0", out_illegal32); end
        if (out_valid64 !== 1'b0)   begin n_fail++; $display("FAIL rst_valid64 got %b exp 0", out_valid64); end
        if (out_result64 !== 64'h0) begin n_fail++; $display("FAIL rst_result64 got %h exp 0", out_result64); end
        if (out_tag64 !== 5'h0)     begin n_fail++; $display("FAIL rst_tag64 got %h exp 0", out_tag64); end
        if (out_illegal64 !== 1'b0) begin n_fail++; $display("FAIL rst_illegal64 got %b exp 0", out_illegal64); end
        @(posedge clk); #3; rst = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready32 got %b exp 1", in_ready32); end
        if (in_ready64 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready64 got %b exp 1", in_ready64); end
    endtask

    typedef struct {
        int          xl;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [63:0] rs1;
        logic        ill;
        logic [63:0] res;
    } vec_t;

    task automatic test_ops;
        vec_t v[12];
        logic        ov, oi;
        logic [63:0] orr;
        logic [4:0]  ot;
        v[0]  = '{32, 7'h13, 3'd0, 12'hFFF, 64'h5,                  1'b0, 64'h4};
        v[1]  = '{32, 7'h13, 3'd3, 12'hFFF, 64'h5,                  1'b0, 64'h1};
        v[2]  = '{32, 7'h13, 3'd2, 12'hFFF, 64'h5,                  1'b0, 64'h0};
        v[3]  = '{32, 7'h13, 3'd5, 12'h41F, 64'h8000_0000,          1'b0, 64'hFFFF_FFFF};
        v[4]  = '{32, 7'h13, 3'd5, 12'h01F, 64'h8000_0000,          1'b0, 64'h1};
        v[5]  = '{32, 7'h13, 3'd1, 12'h020, 64'h8000_0000,          1'b1, 64'h0};
        v[6]  = '{64, 7'h1B, 3'd0, 12'h001, 64'h7FFF_FFFF,          1'b0, 64'hFFFF_FFFF_8000_0000};
        v[7]  = '{64, 7'h13, 3'd1, 12'h03F, 64'h1,                  1'b0, 64'h8000_0000_0000_0000};
        v[8]  = '{32, 7'h1B, 3'd0, 12'h001, 64'h5,                  1'b1, 64'h0};
        v[9]  = '{64, 7'h13, 3'd5, 12'h43F, 64'h8000_0000_0000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        v[10] = '{64, 7'h1B, 3'd5, 12'h41F, 64'h8000_0000,          1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        v[11] = '{32, 7'h13, 3'd5, 12'h21F, 64'h8000_0000,          1'b1, 64'h0};
        idle(3);
        for (int i = 0; i < 12; i++) begin
            drive(v[i].op, v[i].f3, v[i].imm, v[i].rs1, 5'(i + 1));
            @(posedge clk); #1; in_valid = 1'b0;
            @(negedge clk);
            ov = (v[i].xl == 64) ? out_valid64 : out_valid32;
            n_cmp++;
            if (ov !== 1'b0) begin n_fail++; $display("FAIL op%0d_early_valid got %b exp 0", i, ov); end
            @(negedge clk);
            ov  = (v[i].xl == 64) ? out_valid64 : out_valid32;
            oi  = (v[i].xl == 64) ? out_illegal64 : out_illegal32;
            orr = (v[i].xl == 64) ? out_result64 : {32'h0, out_result32};
            ot  = (v[i].xl == 64) ? out_tag64 : out_tag32;
            n_cmp += 4;
            if (ov !== 1'b1)      begin n_fail++; $display("FAIL op%0d_valid got %b exp 1", i, ov); end
            if (oi !== v[i].ill)  begin n_fail++; $display("FAIL op%0d_illegal got %b exp %b", i, oi, v[i].ill); end
            if (orr !== v[i].res) begin n_fail++; $display("FAIL op%0d_result got %h exp %h", i, orr, v[i].res); end
            if (ot !== 5'(i + 1)) begin n_fail++; $display("FAIL op%0d_tag got %0d exp %0d", i, ot, i + 1); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        int          next_tag = 1;
        logic        saw_drop = 1'b0;
        logic [4:0]  held_tag = '0;
        logic [31:0] held_res = '0;
        idle(4);
        got_tags.delete();
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc > 1) begin @(posedge clk); #1; end
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (next_tag <= 6) drive(7'h13, 3'd0, 12'(next_tag), 64'(next_tag * 100), 5'(next_tag));
            else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready32) next_tag++;
            if (!in_ready32) saw_drop = 1'b1;
            if (cyc == 3) begin
                held_tag = out_tag32; held_res = out_result32;
                n_cmp++;
                if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_valid got %b exp 1", out_valid32); end
            end else if (cyc >= 4 && cyc <= 6) begin
                n_cmp += 3;
                if (out_valid32 !== 1'b1)    begin n_fail++; $display("FAIL b2b_hold_valid c%0d got %b exp 1", cyc, out_valid32); end
                if (out_tag32 !== held_tag)  begin n_fail++; $display("FAIL b2b_hold_tag c%0d got %0d exp %0d", cyc, out_tag32, held_tag); end
                if (out_result32 !== held_res) begin n_fail++; $display("FAIL b2b_hold_res c%0d got %h exp %h", cyc, out_result32, held_res); end
            end
        end
        n_cmp += 2;
        if (saw_drop !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_drop got %b exp 1", saw_drop); end
        if (got_tags.size() != 6) begin n_fail++; $display("FAIL b2b_count got %0d exp 6", got_tags.size()); end
        for (int i = 0; i < 6 && i < got_tags.size(); i++) begin
            n_cmp++;
            if (got_tags[i] !== 5'(i + 1)) begin n_fail++; $display("FAIL b2b_order idx%0d got %0d exp %0d", i, got_tags[i], i + 1); end
        end
        idle(1);
    endtask

    task automatic test_flush;
        int found = 0;
        idle(4);
        got_tags.delete();
        out_ready = 1'b0;
        drive(7'h13, 3'd4, 12'h0F0, 64'h1234, 5'd10);
        @(posedge clk); #1;
        drive(7'h13, 3'd6, 12'h00F, 64'h5678, 5'd11);
        @(posedge clk); #1;
        drive(7'h13, 3'd7, 12'hFFF, 64'h9ABC, 5'd12);
        flush = 1'b1;
        @(negedge clk);
        n_cmp += 3;
        if (in_ready32 !== 1'b0)  begin n_fail++; $display("FAIL flush_in_ready32 got %b exp 0", in_ready32); end
        if (in_ready64 !== 1'b0)  begin n_fail++; $display("FAIL flush_in_ready64 got %b exp 0", in_ready64); end
        if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL flush_inflight got %b exp 1", out_valid32); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_cmp += 2;
        if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL flush_valid32 got %b exp 0", out_valid32); end
        if (out_valid64 !== 1'b0) begin n_fail++; $display("FAIL flush_valid64 got %b exp 0", out_valid64); end
        repeat (4) @(negedge clk);
        foreach (got_tags[i]) if (got_tags[i] >= 5'd10 && got_tags[i] <= 5'd12) found++;
        n_cmp++;
        if (found != 0) begin n_fail++; $display("FAIL flush_leak got %0d flushed tags exp 0", found); end
    endtask

    task automatic test_random;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [64:0] e32, e64;
        idle(3);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            flush     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: op = 7'h13;
                6, 7, 8:          op = 7'h1B;
                default:          op = 7'($urandom);
            endcase
            f3  = 3'($urandom);
            imm = 12'($urandom);
            if ($urandom_range(0, 1) == 1) imm = ($urandom_range(0, 1) == 1 ? 12'h400 : 12'h000) | 12'($urandom_range(0, 63));
            drive(op, f3, imm, {32'($urandom), 32'($urandom)}, 5'($urandom));
            in_valid = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            n_cmp += 4;
            if (in_ready32 !== m_in_ready())   begin n_fail++; $display("FAIL rnd%0d_in_ready32 got %b exp %b", i, in_ready32, m_in_ready()); end
            if (in_ready64 !== m_in_ready())   begin n_fail++; $display("FAIL rnd%0d_in_ready64 got %b exp %b", i, in_ready64, m_in_ready()); end
            if (out_valid32 !== m_out_valid()) begin n_fail++; $display("FAIL rnd%0d_valid32 got %b exp %b", i, out_valid32, m_out_valid()); end
            if (out_valid64 !== m_out_valid()) begin n_fail++; $display("FAIL rnd%0d_valid64 got %b exp %b", i, out_valid64, m_out_valid()); end
            if (m_out_valid()) begin
                e32 = q[0].e32;
                e64 = q[0].e64;
                n_cmp += 4;
                if (out_tag32 !== q[0].tag) begin n_fail++; $display("FAIL rnd%0d_tag32 got %0d exp %0d", i, out_tag32, q[0].tag); end
                if (out_tag64 !== q[0].tag) begin n_fail++; $display("FAIL rnd%0d_tag64 got %0d exp %0d", i, out_tag64, q[0].tag); end
                if ({out_illegal32, out_result32} !== {e32[64], e32[31:0]})
                    begin n_fail++; $display("FAIL rnd%0d_res32 got %b/%h exp %b/%h", i, out_illegal32, out_result32, e32[64], e32[31:0]); end
                if ({out_illegal64, out_result64} !== e64)
                    begin n_fail++; $display("FAIL rnd%0d_res64 got %b/%h exp %b/%h", i, out_illegal64, out_result64, e64[64], e64[63:0]); end
            end
        end
        idle(3);
    endtask

    task automatic test_rst_mid;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            drive(7'h13, 3'd0, 12'h011, 64'(i), 5'(20 + i));
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got %b exp 1", out_valid32); end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_cmp += 6;
        if (out_valid32 !== 1'b0)   begin n_fail++; $display("FAIL rstmid_valid32 got %b exp 0", out_valid32); end
        if (out_result32 !== 32'h0) begin n_fail++; $display("FAIL rstmid_result32 got %h exp 0", out_result32); end
        if (out_tag32 !== 5'h0)     begin n_fail++; $display("FAIL rstmid_tag32 got %0d exp 0", out_tag32); end
        if (out_valid64 !== 1'b0)   begin n_fail++; $display("FAIL rstmid_valid64 got %b exp 0", out_valid64); end
        if (out_result64 !== 64'h0) begin n_fail++; $display("FAIL rstmid_result64 got %h exp 0", out_result64); end
        if (out_tag64 !== 5'h0)     begin n_fail++; $display("FAIL rstmid_tag64 got %0d exp 0", out_tag64); end
        @(posedge clk); #3;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        drive(7'h13, 3'd0, 12'h005, 64'd10, 5'd7);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL rstmid_early got %b exp 0", out_valid32); end
        @(negedge clk);
        n_cmp += 5;
        if (out_valid32 !== 1'b1)     begin n_fail++; $display("FAIL rstmid_new_valid32 got %b exp 1", out_valid32); end
        if (out_result32 !== 32'd15)  begin n_fail++; $display("FAIL rstmid_new_res32 got %h exp f", out_result32); end
        if (out_tag32 !== 5'd7)       begin n_fail++; $display("FAIL rstmid_new_tag32 got %0d exp 7", out_tag32); end
        if (out_valid64 !== 1'b1)     begin n_fail++; $display("FAIL rstmid_new_valid64 got %b exp 1", out_valid64); end
        if (out_result64 !== 64'd15)  begin n_fail++; $display("FAIL rstmid_new_res64 got %h exp f", out_result64); end
        idle(2);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_funct3 = '0; in_imm = '0; in_rs1 = '0; in_tag = '0;
        test_reset();
        test_ops();
        test_back_to_back();
        test_flush();
        test_random();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
